// File: rtl/wb_bus_arbiter_rr.sv
// Purpose : round-robin arbiter giving one pipelined Wishbone slave port to one of N_MASTERS masters.
//           A master's CYC is its request. The grant is held for the owner's whole CYC cycle.
// Latency : a request seen at a posedge is granted from that edge (1 cycle). Each grant is followed by 2 idle cycles.
// Backpr. : no preemption and no queueing. Waiting masters hold CYC until granted; a request that drops is forgotten.
//
// Ports
//   clk, rst      system clock; synchronous active-high reset
//   cyc_i         CYC_O of every master (bus request vector)
//   ACK_I/ERR_I/RTY_I  slave cycle terminations, watched by the optional watchdog
//   gnt_o         registered one-hot grant
//   gnt_id_o      binary owner index (bus mux select), meaningful while bus_busy_o=1
//   bus_busy_o    high while any grant is active
//   timeout_o     one-cycle pulse when the watchdog revokes a grant
//
// Build option: define WB_ARB_TIMEOUT_EN to enable the watchdog and the lock-out mask.
// The watchdog revokes a grant that has seen no ACK/ERR/RTY for TIMEOUT_CYCLES cycles.
// A master revoked this way cannot win again until it has dropped CYC.
// When the macro is undefined, a grant lasts until CYC drops and timeout_o stays 0.

module wb_bus_arbiter_rr #(
    parameter int N_MASTERS      = 4,
    parameter int ID_WIDTH       = 2,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TIMEOUT_WIDTH  = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_MASTERS-1:0] cyc_i,
    input  logic                 ACK_I,
    input  logic                 ERR_I,
    input  logic                 RTY_I,
    output logic [N_MASTERS-1:0] gnt_o,
    output logic [ID_WIDTH-1:0]  gnt_id_o,
    output logic                 bus_busy_o,
    output logic                 timeout_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t               state;
    logic [ID_WIDTH-1:0]  rr_ptr;
    logic [N_MASTERS-1:0] lock_mask;
    logic [N_MASTERS-1:0] req;
    logic                 win_vld;
    logic [ID_WIDTH-1:0]  win_id;
    logic [N_MASTERS-1:0] win_onehot;
    logic [ID_WIDTH-1:0]  next_ptr;
    logic [ID_WIDTH:0]    scan_idx;
    logic                 owner_cyc;
    logic                 wd_expire;

    // gnt_o is one-hot, so masking cyc_i with it picks out the owner's CYC
    // without a variable-width index.
    assign owner_cyc = |(cyc_i & gnt_o);

    // Locked-out masters do not compete at all.
    assign req = cyc_i & ~lock_mask;

    // Round-robin search. Scan offsets 0..N-1 from rr_ptr and wrap by
    // subtraction, so a non-power-of-2 N_MASTERS never produces an index past
    // the last master. The first offset that hits a requester wins.
    always_comb begin
        win_vld  = 1'b0;
        win_id   = '0;
        scan_idx = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            scan_idx = {1'b0, rr_ptr} + (ID_WIDTH+1)'(i);
            if (scan_idx >= (ID_WIDTH+1)'(N_MASTERS)) begin
                scan_idx = scan_idx - (ID_WIDTH+1)'(N_MASTERS);
            end
            for (int j = 0; j < N_MASTERS; j++) begin
                if (!win_vld && req[j] && (scan_idx == (ID_WIDTH+1)'(j))) begin
                    win_vld = 1'b1;
                    win_id  = ID_WIDTH'(j);
                end
            end
        end
    end

    always_comb begin
        win_onehot = '0;
        for (int j = 0; j < N_MASTERS; j++) begin
            if (win_id == ID_WIDTH'(j)) begin
                win_onehot[j] = 1'b1;
            end
        end
    end

    // The pointer moves one past the winner, so the winner has lowest priority next time.
    assign next_ptr = (win_id == ID_WIDTH'(N_MASTERS-1)) ? '0 : win_id + ID_WIDTH'(1);

`ifdef WB_ARB_TIMEOUT_EN
    logic [TIMEOUT_WIDTH-1:0] wd_cnt;
    logic                     term;

    assign term = ACK_I | ERR_I | RTY_I;

    // Expiry needs the owner still in its cycle and no termination in the limit cycle.
    // A termination or a CYC drop in that same cycle wins over the timeout.
    assign wd_expire = (state == ST_GRANT) && owner_cyc && !term &&
                       (wd_cnt == TIMEOUT_WIDTH'(TIMEOUT_CYCLES-1));

    // GRANT is only entered from IDLE, so clearing the counter in IDLE
    // gives a zero count on the first granted cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (state == ST_GRANT) begin
            wd_cnt <= term ? '0 : wd_cnt + TIMEOUT_WIDTH'(1);
        end else begin
            wd_cnt <= '0;
        end
    end

    // A lock bit lasts only while its master keeps CYC high. On expiry the
    // owner's CYC is high by definition, so OR-ing in gnt_o sets the bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_mask <= '0;
        end else begin
            lock_mask <= (lock_mask & cyc_i) | (wd_expire ? gnt_o : '0);
        end
    end
`else
    logic                     unused_term;
    logic [TIMEOUT_WIDTH-1:0] unused_limit;

    assign lock_mask    = '0;
    assign wd_expire    = 1'b0;
    assign unused_term  = ACK_I ^ ERR_I ^ RTY_I;
    assign unused_limit = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);
`endif

    // Arbitration FSM. All outputs are registered here, so gnt_o never
    // depends combinationally on cyc_i.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            gnt_o      <= '0;
            gnt_id_o   <= '0;
            bus_busy_o <= 1'b0;
            timeout_o  <= 1'b0;
            rr_ptr     <= '0;
        end else begin
            timeout_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (win_vld) begin
                        state      <= ST_GRANT;
                        gnt_o      <= win_onehot;
                        gnt_id_o   <= win_id;
                        bus_busy_o <= 1'b1;
                        rr_ptr     <= next_ptr;
                    end
                end
                ST_GRANT: begin
                    // Requests from other masters are ignored here; the owner keeps the bus.
                    if (!owner_cyc || wd_expire) begin
                        state      <= ST_RELEASE;
                        gnt_o      <= '0;
                        bus_busy_o <= 1'b0;
                        timeout_o  <= wd_expire;
                    end
                end
                ST_RELEASE: begin
                    // One turnaround cycle with no owner, so the slave sees a clean gap.
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
